// File: rtl/ecc_hamming_decoder_pipe.sv
// ecc_hamming_decoder_pipe
//   Two-stage pipelined Hamming SEC/SECDED decoder with valid/ready handshake.
//   Stage 1 registers the codeword, its syndrome and the overall parity check.
//   Stage 2 classifies the word, corrects a single error, and extracts data.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     input handshake
//   codeword[C-1:0]       received codeword, codeword[k] = Hamming position k+1
//   extra_parity          received overall (even) parity bit
//   out_valid/out_ready   output handshake
//   dout[D-1:0]           corrected data
//   sec, ded              single error corrected / uncorrectable error detected
//   err_pos[P-1:0]        syndrome (0 = no error or error in extra_parity)
//   cnt_clr               synchronous clear of the error counters
//   sec_cnt, ded_cnt      saturating error counters
//
// Optional feature macro: ECC_HAMMING_ERR_CNT_EN
//   defined   -> sec_cnt/ded_cnt count output handshakes carrying sec/ded
//   undefined -> counters tied to 0, cnt_clr ignored

module ecc_hamming_decoder_pipe #(
  parameter int D      = 4,
  parameter int C      = 7,
  parameter int SECDED = 1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [C-1:0]     codeword,
  input  logic             extra_parity,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [D-1:0]     dout,
  output logic             sec,
  output logic             ded,
  output logic [C-D-1:0]   err_pos,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] sec_cnt,
  output logic [CNT_W-1:0] ded_cnt
);

  localparam int P = C - D;

  // Bit k (1-based Hamming position) of a codeword.
  function automatic logic cw_bit(input logic [C-1:0] cw, input int k);
    return |(cw & (C'(1) << (k - 1)));
  endfunction

  // s[i] = XOR of all positions whose index has bit i set.
  function automatic logic [P-1:0] calc_syndrome(input logic [C-1:0] cw);
    logic [P-1:0] s;
    s = '0;
    for (int i = 0; i < P; i++) begin
      for (int k = 1; k <= C; k++) begin
        if (((k >> i) & 1) != 0) begin
          s = s ^ (P'(cw_bit(cw, k)) << i);
        end
      end
    end
    return s;
  endfunction

  // Data sits at the non-power-of-two positions, lowest data bit first.
  function automatic logic [D-1:0] extract_data(input logic [C-1:0] cw);
    logic [D-1:0] d;
    int           j;
    d = '0;
    j = 0;
    for (int k = 1; k <= C; k++) begin
      if ((k & (k - 1)) != 0) begin
        if (j < D) begin
          d = d | (D'(cw_bit(cw, k)) << j);
        end
        j++;
      end
    end
    return d;
  endfunction

  // Stage registers
  logic         v1_q, v2_q;
  logic [C-1:0] cw1_q;
  logic [P-1:0] s1_q;
  logic         p1_q;
  logic [D-1:0] dout_q;
  logic         sec_q, ded_q;
  logic [P-1:0] pos_q;

  // Next-state values
  logic [P-1:0] s_d;
  logic         p_d;
  logic [C-1:0] corr_d;
  logic [D-1:0] dout_d;
  logic         sec_d, ded_d;

  logic adv1, adv2;

  // A stage may load when it is empty or its content moves on this cycle.
  assign adv2     = !v2_q || out_ready;
  assign adv1     = !v1_q || adv2;
  assign in_ready = adv1;

  assign s_d = calc_syndrome(codeword);
  assign p_d = (SECDED != 0) ? (^codeword ^ extra_parity) : 1'b0;

  always_comb begin
    corr_d = cw1_q;
    sec_d  = 1'b0;
    ded_d  = 1'b0;
    if (s1_q == '0) begin
      // Only the extra parity bit can be wrong; data is untouched.
      sec_d = p1_q;
    end else if (int'(s1_q) > C) begin
      // Syndrome points outside the codeword: cannot be a single error.
      ded_d = 1'b1;
    end else if (p1_q || (SECDED == 0)) begin
      corr_d = cw1_q ^ (C'(1) << (int'(s1_q) - 1));
      sec_d  = 1'b1;
    end else begin
      // Non-zero syndrome with even overall parity: two bits flipped.
      ded_d = 1'b1;
    end
    dout_d = extract_data(corr_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q  <= 1'b0;
      cw1_q <= '0;
      s1_q  <= '0;
      p1_q  <= 1'b0;
    end else if (adv1) begin
      v1_q <= in_valid;
      if (in_valid) begin
        cw1_q <= codeword;
        s1_q  <= s_d;
        p1_q  <= p_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_q   <= 1'b0;
      dout_q <= '0;
      sec_q  <= 1'b0;
      ded_q  <= 1'b0;
      pos_q  <= '0;
    end else if (adv2) begin
      v2_q <= v1_q;
      // Result registers only change when a new word arrives, so a stalled
      // or drained output keeps its last value.
      if (v1_q) begin
        dout_q <= dout_d;
        sec_q  <= sec_d;
        ded_q  <= ded_d;
        pos_q  <= s1_q;
      end
    end
  end

  assign out_valid = v2_q;
  assign dout      = dout_q;
  assign sec       = sec_q;
  assign ded       = ded_q;
  assign err_pos   = pos_q;

`ifdef ECC_HAMMING_ERR_CNT_EN
  logic [CNT_W-1:0] sec_cnt_q, ded_cnt_q;
  logic             out_hs;

  assign out_hs = v2_q && out_ready;

  // Clear has priority over a simultaneous increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec_cnt_q <= '0;
      ded_cnt_q <= '0;
    end else if (cnt_clr) begin
      sec_cnt_q <= '0;
      ded_cnt_q <= '0;
    end else begin
      if (out_hs && sec_q && (sec_cnt_q != '1)) begin
        sec_cnt_q <= sec_cnt_q + CNT_W'(1);
      end
      if (out_hs && ded_q && (ded_cnt_q != '1)) begin
        ded_cnt_q <= ded_cnt_q + CNT_W'(1);
      end
    end
  end

  assign sec_cnt = sec_cnt_q;
  assign ded_cnt = ded_cnt_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign sec_cnt        = '0;
  assign ded_cnt        = '0;
`endif

endmodule

// File: tb/tb_ecc_hamming_decoder_pipe.sv
module tb_ecc_hamming_decoder_pipe;

  typedef struct packed {
    logic [3:0] dout;
    logic       sec;
    logic       ded;
    logic [2:0] pos;
  } exp_t;

`ifdef ECC_HAMMING_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [6:0] codeword;
  logic       extra_parity;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] dout;
  logic       sec;
  logic       ded;
  logic [2:0] err_pos;
  logic       cnt_clr;
  logic [1:0] sec_cnt;
  logic [1:0] ded_cnt;

  ecc_hamming_decoder_pipe #(.D(4), .C(7), .SECDED(1), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .codeword(codeword), .extra_parity(extra_parity),
    .out_valid(out_valid), .out_ready(out_ready),
    .dout(dout), .sec(sec), .ded(ded), .err_pos(err_pos),
    .cnt_clr(cnt_clr), .sec_cnt(sec_cnt), .ded_cnt(ded_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];
  int   ready_mode = 0;  // 0: out_ready=1, 1: random, 2: out_ready=0
  int   m_sec = 0;
  int   m_ded = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [3:0] d, input logic s, input logic dd, input logic [2:0] p);
    exp_t e;
    e.dout = d; e.sec = s; e.ded = dd; e.pos = p;
    return e;
  endfunction

  function automatic logic [6:0] enc(input logic [3:0] d);
    logic p1, p2, p4;
    p1 = d[0] ^ d[1] ^ d[3];
    p2 = d[0] ^ d[2] ^ d[3];
    p4 = d[1] ^ d[2] ^ d[3];
    return {d[3], d[2], d[1], p4, d[0], p2, p1};
  endfunction

  // Reference decoder: syndrome as XOR of the indices of all set positions.
  function automatic exp_t ref_decode(input logic [6:0] cw, input logic ep);
    logic [2:0] s;
    logic       par;
    logic [6:0] fx;
    exp_t       e;
    s = 3'd0;
    par = ep;
    for (int k = 1; k <= 7; k++) begin
      if (((cw >> (k - 1)) & 7'd1) != 7'd0) begin
        s = s ^ 3'(k);
        par = ~par;
      end
    end
    fx = cw;
    e.sec = 1'b0;
    e.ded = 1'b0;
    if (s == 3'd0) e.sec = par;
    else if (par) begin
      fx = fx ^ (7'd1 << (s - 3'd1));
      e.sec = 1'b1;
    end else e.ded = 1'b1;
    e.dout = {fx[6], fx[5], fx[4], fx[2]};
    e.pos = s;
    return e;
  endfunction

  task automatic send(input logic [6:0] cw, input logic ep, input exp_t e);
    int wait_cyc;
    @(negedge clk);
    in_valid = 1'b1;
    codeword = cw;
    extra_parity = ep;
    wait_cyc = 0;
    #2;
    while (!in_ready && wait_cyc < 200) begin
      @(negedge clk);
      #2;
      wait_cyc++;
    end
    if (in_ready) begin
      sb.push_back(e);
      @(posedge clk);
    end else begin
      check_eq("send_timeout", {31'd0, in_ready}, 32'd1);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain", sb.size(), 0);
    @(negedge clk);
  endtask

  // Output monitor, out_ready driver and counter model.
  exp_t       mon_e;
  logic       held;
  logic [3:0] h_dout;
  logic       h_sec, h_ded;
  logic [2:0] h_pos;

  initial begin
    out_ready = 1'b1;
    held = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 1) == 1);
        default: out_ready = 1'b0;
      endcase
      #1;
      if (!rst_n) begin
        sb.delete();
        m_sec = 0;
        m_ded = 0;
        held = 1'b0;
      end else begin
        check_eq("sec_cnt", {30'd0, sec_cnt}, m_sec);
        check_eq("ded_cnt", {30'd0, ded_cnt}, m_ded);
        if (held) begin
          check_eq("stall_valid", {31'd0, out_valid}, 32'd1);
          check_eq("stall_dout", {28'd0, dout}, {28'd0, h_dout});
          check_eq("stall_flags", {30'd0, sec, ded}, {30'd0, h_sec, h_ded});
          check_eq("stall_pos", {29'd0, err_pos}, {29'd0, h_pos});
        end
        if (!in_ready) check_eq("in_ready_low", {31'd0, out_valid && !out_ready}, 32'd1);
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            check_eq("unexpected_out", {31'd0, out_valid}, 32'd0);
          end else begin
            mon_e = sb.pop_front();
            check_eq("dout", {28'd0, dout}, {28'd0, mon_e.dout});
            check_eq("sec", {31'd0, sec}, {31'd0, mon_e.sec});
            check_eq("ded", {31'd0, ded}, {31'd0, mon_e.ded});
            check_eq("err_pos", {29'd0, err_pos}, {29'd0, mon_e.pos});
            if (CNT_EN && !cnt_clr) begin
              if (mon_e.sec && m_sec != 3) m_sec++;
              if (mon_e.ded && m_ded != 3) m_ded++;
            end
          end
        end
        if (cnt_clr) begin
          m_sec = 0;
          m_ded = 0;
        end
        held = out_valid && !out_ready;
        h_dout = dout;
        h_sec = sec;
        h_ded = ded;
        h_pos = err_pos;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] cw;
    logic [7:0] v;
    logic [3:0] d;
    int         nflip, b1, b2;

    rst_n = 1'b0;
    in_valid = 1'b0;
    codeword = 7'd0;
    extra_parity = 1'b0;
    cnt_clr = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_dout", {28'd0, dout}, 32'd0);
    check_eq("rst_flags", {30'd0, sec, ded}, 32'd0);
    check_eq("rst_err_pos", {29'd0, err_pos}, 32'd0);
    check_eq("rst_cnts", {28'd0, sec_cnt, ded_cnt}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("in_ready_after_rst", {31'd0, in_ready}, 32'd1);

    // Clean word with latency check
    send(7'h55, 1'b0, mk(4'b1011, 1'b0, 1'b0, 3'd0));
    idle();
    check_eq("lat_early", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check_eq("lat_2", {31'd0, out_valid}, 32'd1);

    send(7'h45, 1'b0, mk(4'b1011, 1'b1, 1'b0, 3'd5));
    send(7'h56, 1'b0, mk(4'b1011, 1'b0, 1'b1, 3'd3));
    send(7'h55, 1'b1, mk(4'b1011, 1'b1, 1'b0, 3'd0));
    idle();
    drain();
    check_eq("sec_cnt_dir", {30'd0, sec_cnt}, CNT_EN ? 32'd2 : 32'd0);
    check_eq("ded_cnt_dir", {30'd0, ded_cnt}, CNT_EN ? 32'd1 : 32'd0);

    // All 16 clean encodings under random backpressure
    ready_mode = 1;
    for (int i = 0; i < 16; i++) begin
      cw = enc(4'(i));
      send(cw, ^cw, mk(4'(i), 1'b0, 1'b0, 3'd0));
    end
    idle();
    drain();

    // Random 0/1/2-bit errors (including the extra parity bit)
    for (int i = 0; i < 24; i++) begin
      d = 4'($urandom_range(0, 15));
      cw = enc(d);
      v = {^cw, cw};
      nflip = $urandom_range(0, 2);
      b1 = $urandom_range(0, 7);
      b2 = (b1 + $urandom_range(1, 7)) % 8;
      if (nflip >= 1) v = v ^ (8'd1 << b1);
      if (nflip == 2) v = v ^ (8'd1 << b2);
      send(v[6:0], v[7], ref_decode(v[6:0], v[7]));
    end
    idle();
    drain();
    ready_mode = 0;

    // Saturation: four sec words after a clear
    @(negedge clk);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    repeat (4) send(7'h45, 1'b0, mk(4'b1011, 1'b1, 1'b0, 3'd5));
    idle();
    drain();
    check_eq("sec_cnt_sat", {30'd0, sec_cnt}, CNT_EN ? 32'd3 : 32'd0);

    // Clear coinciding with a sec handshake
    ready_mode = 2;
    send(7'h45, 1'b0, mk(4'b1011, 1'b1, 1'b0, 3'd5));
    idle();
    @(negedge clk);
    check_eq("stalled_valid", {31'd0, out_valid}, 32'd1);
    cnt_clr = 1'b1;
    ready_mode = 0;
    @(negedge clk);
    cnt_clr = 1'b0;
    check_eq("clr_vs_inc", {30'd0, sec_cnt}, 32'd0);
    drain();

    // Reset with two words in flight
    ready_mode = 2;
    send(7'h55, 1'b0, mk(4'b1011, 1'b0, 1'b0, 3'd0));
    send(enc(4'd6), ^enc(4'd6), mk(4'd6, 1'b0, 1'b0, 3'd0));
    idle();
    check_eq("in_ready_full", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ready_mode = 0;
    repeat (4) @(negedge clk);
    check_eq("no_stale_out", {31'd0, out_valid}, 32'd0);
    check_eq("sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
